arb_grant_lock_mux: RTL

//  Consumer stage for the MSB-first priority arbiter: drives the arbiter's req vector,

---
 rtl/arb_grant_lock_mux.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/arb_grant_lock_mux.sv
// Consumer stage for an external priority arbiter: captures a one-hot grant, locks it
// for a whole packet and muxes the owner's valid/data/last onto one downstream port.
module arb_grant_lock_mux #(
  parameter int SIZE      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SIZE-1:0]          req_valid,
  input  logic [SIZE-1:0]          req_last,
  input  logic [SIZE*DATA_W-1:0]   req_data,
  output logic [SIZE-1:0]          req_ready,
  output logic [SIZE-1:0]          arb_req,
  input  logic [SIZE-1:0]          arb_gnt,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [$clog2(SIZE)-1:0]  out_src,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     gnt_err,
  output logic                     wdog_err,
  output logic [CNT_W-1:0]         grant_cnt
);

  localparam int SRC_W  = $clog2(SIZE);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [SIZE-1:0]     owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    grant_cnt_q, grant_cnt_d;
  logic                gnt_err_q, gnt_err_d;
  logic                wdog_err_q, wdog_err_d;

  logic [SRC_W-1:0]    owner_idx;
  logic                owner_valid, owner_last;
  logic [DATA_W-1:0]   owner_data;
  logic                locked, any_valid, gnt_ok, beat, beat_lim, wdog_hit;

  // Owner is held one-hot; decode index and select its lane in one pass.
  always_comb begin
    owner_idx   = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (owner_q[i]) begin
        owner_idx   = SRC_W'(i);
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign locked    = (state_q == LOCKED) && !rst;
  assign any_valid = |req_valid;
  assign gnt_ok    = $onehot(arb_gnt) && |(arb_gnt & req_valid);
  assign beat      = locked && owner_valid && out_ready;
  assign beat_lim  = (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));
  assign wdog_hit  = beat && beat_lim && !owner_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      grant_cnt_q <= '0;
      gnt_err_q   <= 1'b0;
      wdog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      grant_cnt_q <= grant_cnt_d;
      gnt_err_q   <= gnt_err_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    grant_cnt_d = grant_cnt_q;
    gnt_err_d   = 1'b0;
    wdog_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          if (gnt_ok) begin
            owner_d     = arb_gnt;
            beat_cnt_d  = '0;
            grant_cnt_d = grant_cnt_q + 1'b1;
            state_d     = LOCKED;
          end else begin
            gnt_err_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (owner_last) begin
            state_d = IDLE;
          end else if (beat_lim) begin
            wdog_err_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_src   = '0;
    arb_req   = (state_q == IDLE && !rst) ? req_valid : '0;
    if (locked) begin
      req_ready = owner_q & {SIZE{out_ready}};
      out_valid = owner_valid;
      out_data  = owner_data;
      out_last  = owner_last | wdog_hit;
      out_src   = owner_idx;
    end
  end

  assign busy      = locked;
  assign gnt_err   = gnt_err_q;
  assign wdog_err  = wdog_err_q;
  assign grant_cnt = grant_cnt_q;

endmodule
